dl_report_arbiter: RTL
======================

DL_REPORT_ARBITER -- requirements
Module: dl_report_arbiter

Interface
REQ-001 Parameter N_PROC, default 2: number of monitored processes; legal range is 2..16.
REQ-002 Parameter CONFIRM_CYC, default 4: consecutive cycles an origin's dl_in bit must stay high before a deadlock is declared; legal range is 1..255.
REQ-003 Parameter CNT_W, default 32: width of the free-running cycle counter.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port clock, input, 1 bit: all state updates on the rising edge.
REQ-006 The block SHALL have port dl_in_vec, input, N_PROC bits: per-process deadlock-candidate flags from the detect units.
REQ-007 The block SHALL have port rearm, input, 1 bit: single-cycle pulse that releases a declared deadlock.
REQ-008 The block SHALL have port dl_detect_out, output, 1 bit: deadlock declared; sticky.
REQ-009 The block SHALL have port origin, output, N_PROC bits: one-hot marker of the candidate origin process.
REQ-010 The block SHALL have port token_clear, output, 1 bit: one-cycle pulse that tells the detect units to discard in-flight tokens.
REQ-011 The block SHALL have port rpt_valid, output, 1 bit: report valid.
REQ-012 The block SHALL have port rpt_ready, input, 1 bit: report accepted.
REQ-013 The block SHALL have port rpt_idx, output, IDX_W bits: index of the origin process, where IDX_W = max(1, ceil(log2(N_PROC))).
REQ-014 The block SHALL have port rpt_cycle, output, CNT_W bits: cycle-counter value captured at declaration.
REQ-015 The block SHALL have port rpt_vec, output, N_PROC bits: snapshot of dl_in_vec captured at declaration.

Function
REQ-016 The block SHALL implement a four-state FSM with states IDLE, CONFIRM, REPORT and HOLD.
REQ-017 The block SHALL maintain a free-running counter cyc_cnt that increments by 1 every cycle and wraps from 2^CNT_W-1 to 0.
REQ-018 In IDLE, if any dl_in_vec bit is 1, the block SHALL latch the lowest-index set bit as candidate, set the confirm counter to 1, and go to CONFIRM on the next edge.
REQ-019 When several dl_in_vec bits rise in the same cycle, the lowest index SHALL win.
REQ-020 origin SHALL equal the one-hot candidate in CONFIRM, REPORT and HOLD, and SHALL be all-zero in IDLE.
REQ-021 In CONFIRM, while dl_in_vec[candidate] = 1, the confirm counter SHALL increment each cycle.
REQ-022 When the confirm counter reaches CONFIRM_CYC, the block SHALL on the next edge:
- set dl_detect_out to 1;
- capture cyc_cnt into rpt_cycle and dl_in_vec into rpt_vec;
- go to REPORT.
REQ-023 With CONFIRM_CYC = 1, the FSM SHALL pass through CONFIRM for exactly one cycle.
REQ-024 In CONFIRM, if dl_in_vec[candidate] = 0, the block SHALL:
- assert token_clear for exactly that one cycle (a combinational pulse);
- abandon the candidate;
- return to IDLE.
Changes on other dl_in_vec bits SHALL be ignored during CONFIRM.
REQ-025 In REPORT, rpt_valid SHALL be 1, and rpt_idx, rpt_cycle and rpt_vec SHALL stay stable until the cycle in which rpt_valid & rpt_ready, after which the FSM SHALL go to HOLD.
REQ-026 rpt_valid SHALL NOT depend combinationally on rpt_ready.
REQ-027 In REPORT and HOLD, dl_detect_out SHALL stay 1 regardless of dl_in_vec.
REQ-028 In HOLD, rearm = 1 SHALL:
- pulse token_clear for one cycle;
- clear dl_detect_out and origin on the next edge;
- return to IDLE.
REQ-029 rearm SHALL be ignored in IDLE, CONFIRM and REPORT.
REQ-030 rpt_valid SHALL be 0 in every state except REPORT.
REQ-031 Re-entry SHALL be possible: after returning to IDLE, a still-high dl_in bit SHALL start a new CONFIRM on the following edge.

Reset
REQ-032 Asserting reset (reset = 0) SHALL asynchronously force:
- FSM to IDLE;
- dl_detect_out, origin, token_clear, rpt_valid, rpt_idx, rpt_cycle, rpt_vec, cyc_cnt and the confirm counter to 0.
REQ-033 Reset asserted mid-CONFIRM or mid-REPORT SHALL drop any pending report without a token_clear pulse.
REQ-034 The first cyc_cnt increment SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-035 Confirmation path (N_PROC=2, CONFIRM_CYC=4): dl_in_vec=2'b10 held from cycle 10 -> origin=2'b10 from cycle 11; dl_detect_out=1 and rpt_valid=1 from cycle 14; rpt_idx=1, rpt_cycle=13, rpt_vec=2'b10.
REQ-036 Glitch rejection: dl_in_vec=2'b01 for 2 cycles, then 0 -> one token_clear pulse in the cycle the bit drops, no dl_detect_out, FSM back in IDLE.
REQ-037 Simultaneous candidates: dl_in_vec=2'b11 held -> origin=2'b01, rpt_idx=0, rpt_vec=2'b11.
REQ-038 Backpressure: rpt_ready=0 for 20 cycles in REPORT -> rpt_valid held 1 with unchanged payload; rpt_ready=1 -> HOLD next cycle with rpt_valid=0; rearm pulse -> token_clear for 1 cycle, dl_detect_out=0 next cycle.
REQ-039 Wrap and reset: preload cyc_cnt near 2^CNT_W-1 (CNT_W=8, declaration at count 255) -> rpt_cycle=255 and cyc_cnt=0 next cycle; reset asserted in REPORT -> all outputs 0 immediately, with no token_clear pulse.

Source files
------------

// File: rtl/dl_report_arbiter.sv
// Deadlock report arbiter: confirms a persistent candidate from the
// detect units, reports it once over a valid/ready port and holds until rearmed.
module dl_report_arbiter #(
    parameter int N_PROC      = 2,
    parameter int CONFIRM_CYC = 4,
    parameter int CNT_W       = 32,
    localparam int IDX_W      = (N_PROC > 2) ? $clog2(N_PROC) : 1
) (
    input  logic              reset,
    input  logic              clock,
    input  logic [N_PROC-1:0] dl_in_vec,
    input  logic              rearm,
    output logic              dl_detect_out,
    output logic [N_PROC-1:0] origin,
    output logic              token_clear,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [IDX_W-1:0]  rpt_idx,
    output logic [CNT_W-1:0]  rpt_cycle,
    output logic [N_PROC-1:0] rpt_vec
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_REPORT  = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    localparam logic [8:0] CONF_LIM = 9'(CONFIRM_CYC);

    logic [1:0]        state;
    logic [IDX_W-1:0]  cand;
    logic [7:0]        conf;
    logic [CNT_W-1:0]  cyc_cnt;
    logic [IDX_W-1:0]  low_idx;
    logic [N_PROC-1:0] cand_oh;
    logic              any_set;
    logic              cand_hit;
    logic              conf_done;

    // Lowest-index set bit wins when several candidates rise together
    always_comb begin
        low_idx = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (dl_in_vec[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    assign any_set  = |dl_in_vec;
    assign cand_oh  = {{(N_PROC-1){1'b0}}, 1'b1} << cand;
    assign cand_hit = |(dl_in_vec & cand_oh);

    // The IDLE cycle counts as the first high cycle, so the current
    // confirm cycle completes the window when conf + 1 reaches the limit.
    assign conf_done = ({1'b0, conf} + 9'd1) >= CONF_LIM;

    assign origin        = (state == S_IDLE) ? '0 : cand_oh;
    assign dl_detect_out = (state == S_REPORT) || (state == S_HOLD);
    assign rpt_valid     = (state == S_REPORT);
    assign token_clear   = ((state == S_CONFIRM) && !cand_hit) ||
                           ((state == S_HOLD) && rearm);

    // Free-running timestamp counter, wraps naturally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
        end
    end

    // Candidate confirmation, report handshake and hold/rearm sequencing
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cand      <= '0;
            conf      <= '0;
            rpt_idx   <= '0;
            rpt_cycle <= '0;
            rpt_vec   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_set) begin
                        cand  <= low_idx;
                        conf  <= 8'd1;
                        state <= S_CONFIRM;
                    end
                end
                S_CONFIRM: begin
                    if (!cand_hit) begin
                        state <= S_IDLE;
                    end else if (conf_done) begin
                        state     <= S_REPORT;
                        rpt_idx   <= cand;
                        rpt_cycle <= cyc_cnt;
                        rpt_vec   <= dl_in_vec;
                    end else begin
                        conf <= conf + 8'd1;
                    end
                end
                S_REPORT: begin
                    if (rpt_ready) begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (rearm) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
